// File: rtl/bounce_counter_pkg.sv
// bounce_counter_pkg
// Shared definitions for the bounce_counter slice: the run-mode encodings
// presented on the mode input and the direction state machine's states.
// The HOLD_TOP/HOLD_BOT states are only entered when the design is built
// with BOUNCE_COUNTER_DWELL_EN defined.
package bounce_counter_pkg;

  // Run modes, sampled by the counter on strobe cycles only.
  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_BOUNCE    = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  // Direction state machine used by bounce mode.
  typedef enum logic [1:0] {
    UP       = 2'b00,
    DOWN     = 2'b01,
    HOLD_TOP = 2'b10,
    HOLD_BOT = 2'b11
  } state_e;

endpackage

// File: rtl/bounce_counter_if.sv
// bounce_counter_if
// Groups the control and LED-side signals of bounce_counter.
//   en   : run enable (driven by master)
//   mode : run mode, see bounce_counter_pkg::mode_e (driven by master)
//   out  : current count / LED pattern (driven by slave)
//   dir  : 1 = counting up, 0 = counting down (driven by slave)
//   tick : one-cycle pulse on each newly stepped value (driven by slave)
//   turn : one-cycle pulse with tick on a wrap or reversal (driven by slave)
interface bounce_counter_if #(
  parameter int WIDTH = 4
);
  import bounce_counter_pkg::*;

  logic             en;
  mode_e            mode;
  logic [WIDTH-1:0] out;
  logic             dir;
  logic             tick;
  logic             turn;

  modport master (output en, mode, input out, dir, tick, turn);
  modport slave  (input en, mode, output out, dir, tick, turn);

endinterface

// File: rtl/bounce_counter_tick_strobe.sv
// tick_strobe
// One-cycle enable generator: raises stb for one clk cycle every DIV_COUNT
// cycles while en is high. Dropping en clears the divider, so the next
// strobe comes a full DIV_COUNT cycles after en returns.
// Ports: clk, rst (async, active high), en (run enable), stb (strobe out).
module tick_strobe #(
  parameter int DIV_COUNT = 1500000,
  parameter int DIV_WIDTH = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic stb
);

  localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIV_COUNT - 1);

  if (DIV_COUNT < 1 || longint'(DIV_COUNT) > (longint'(1) << DIV_WIDTH)) begin : g_bad_div
    $error("tick_strobe: DIV_COUNT must be >= 1 and fit in DIV_WIDTH bits");
  end

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;

  // Strobe on the last count of the period; with DIV_COUNT=1 LAST is 0 and
  // the counter never leaves 0, so stb simply follows en.
  always_comb begin
    stb       = en && (div_cnt_q == LAST);
    div_cnt_d = div_cnt_q + 1'b1;
    if (!en || stb) begin
      div_cnt_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/bounce_counter.sv
// bounce_counter
// LED pattern counter stepping between MIN_VAL and MAX_VAL once per internal
// tick, in up-wrap, down-wrap, bounce or hold mode. All outputs are
// registered; tick/turn rise one cycle after the internal strobe, on the
// same edge the new count appears.
// Ports: clk, rst (async, active high), bus (bounce_counter_if.slave:
//   en, mode in; out, dir, tick, turn out).
// Build option: BOUNCE_COUNTER_DWELL_EN makes bounce mode dwell one extra
//   tick at each endpoint via the HOLD_TOP/HOLD_BOT states.
module bounce_counter
  import bounce_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 15,
  parameter int DIV_COUNT = 1500000,
  parameter int DIV_WIDTH = 24
) (
  input  logic              clk,
  input  logic              rst,
  bounce_counter_if.slave   bus
);

  if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
      longint'(MAX_VAL) > (longint'(1) << WIDTH) - 1) begin : g_bad_bounds
    $error("bounce_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_P1_V = WIDTH'(MIN_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_M1_V = WIDTH'(MAX_VAL - 1);

  logic             stb;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             turn_q, turn_d;
  state_e           state_q, state_d;

  tick_strobe #(
    .DIV_COUNT(DIV_COUNT),
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_strobe (
    .clk(clk),
    .rst(rst),
    .en (bus.en),
    .stb(stb)
  );

  // Next-state logic: everything holds unless this is a strobe cycle.
  // Wrap modes keep the bounce state aligned with the forced direction so
  // that a later switch to bounce resumes without a jump.
  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    state_d = state_q;
    tick_d  = stb;
    turn_d  = 1'b0;
    if (stb) begin
      case (bus.mode)
        MODE_UP_WRAP: begin
          dir_d   = 1'b1;
          state_d = UP;
          if (out_q == MAX_V) begin
            out_d  = MIN_V;
            turn_d = 1'b1;
          end else begin
            out_d = out_q + 1'b1;
          end
        end
        MODE_DOWN_WRAP: begin
          dir_d   = 1'b0;
          state_d = DOWN;
          if (out_q == MIN_V) begin
            out_d  = MAX_V;
            turn_d = 1'b1;
          end else begin
            out_d = out_q - 1'b1;
          end
        end
        MODE_BOUNCE: begin
          case (state_q)
            UP: begin
              if (out_q == MAX_V) begin
                dir_d  = 1'b0;
                turn_d = 1'b1;
`ifdef BOUNCE_COUNTER_DWELL_EN
                state_d = HOLD_TOP;
`else
                state_d = DOWN;
                out_d   = MAX_M1_V;
`endif
              end else begin
                out_d = out_q + 1'b1;
              end
            end
            DOWN: begin
              if (out_q == MIN_V) begin
                dir_d  = 1'b1;
                turn_d = 1'b1;
`ifdef BOUNCE_COUNTER_DWELL_EN
                state_d = HOLD_BOT;
`else
                state_d = UP;
                out_d   = MIN_P1_V;
`endif
              end else begin
                out_d = out_q - 1'b1;
              end
            end
`ifdef BOUNCE_COUNTER_DWELL_EN
            HOLD_TOP: begin
              out_d   = out_q - 1'b1;
              state_d = DOWN;
            end
            HOLD_BOT: begin
              out_d   = out_q + 1'b1;
              state_d = UP;
            end
`endif
            default: begin
              state_d = dir_q ? UP : DOWN;
            end
          endcase
        end
        MODE_HOLD: begin
          out_d = out_q;
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= MIN_V;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      turn_q  <= 1'b0;
      state_q <= UP;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      turn_q  <= turn_d;
      state_q <= state_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.dir  = dir_q;
  assign bus.tick = tick_q;
  assign bus.turn = turn_q;

endmodule

// File: doc/bounce_counter.md
# bounce_counter

Parametrised, single-clock LED pattern counter. It counts between programmable bounds in up-wrap, down-wrap or bounce (up/down ping-pong) mode, advancing once per internally generated tick. It replaces the divided-clock, two-counter-FSM arrangement with one clock domain, a tick strobe and a single direction state machine. It drives the board LEDs directly and exposes tick and turn pulses for downstream sequencing.

## Interface
- WIDTH, 4: counter width in bits.
- MIN_VAL, 0: lower bound; the counter's reset value.
- MAX_VAL, 15: upper bound. Legal range is MIN_VAL < MAX_VAL ≤ 2^WIDTH−1; elaboration fails otherwise.
- DIV_COUNT, 1500000: clk cycles per tick, ≥1 (12 MHz → 8 Hz).
- DIV_WIDTH, 24: divider counter width. Must satisfy 2^DIV_WIDTH ≥ DIV_COUNT.
- clk  in  1  system clock (12 MHz).
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable. While low, the divider is cleared and held at 0, no ticks occur, and all state is frozen.
- mode  in  2  00 up-wrap, 01 down-wrap, 10 bounce, 11 hold. Sampled only on strobe cycles.
- out  out  WIDTH  current count; drives the LEDs.
- dir  out  1  1 = counting up, 0 = counting down.
- tick  out  1  one-cycle pulse, high during the first cycle `out` shows a newly stepped value.
- turn  out  1  one-cycle pulse coincident with tick when a wrap or a direction reversal was taken.

## Operation
- Reset values: out=MIN_VAL, dir=1, tick=0, turn=0, divider=0, state UP.
- Divider:
  - Internal stb=1 when en=1 and div_cnt==DIV_COUNT−1. On that edge div_cnt returns to 0; otherwise it increments.
  - With DIV_COUNT=1, stb=en.
- All count, dir and state updates occur only on stb edges. tick and turn are registered, so they rise one cycle after the stb edge.
- Up-wrap (00):
  - dir forced to 1.
  - out+1, except out==MAX_VAL → MIN_VAL with turn=1.
- Down-wrap (01):
  - dir forced to 0.
  - out−1, except out==MIN_VAL → MAX_VAL with turn=1.
- Bounce (10), FSM states UP, DOWN:
  - UP: out<MAX_VAL → out+1. out==MAX_VAL → out=MAX_VAL−1, dir=0, state DOWN, turn=1.
  - DOWN: out>MIN_VAL → out−1. out==MIN_VAL → out=MIN_VAL+1, dir=1, state UP, turn=1.
  - Each endpoint is shown for exactly one tick.
- Hold (11): out, dir and state unchanged. tick still pulses, turn=0.
- Mode change takes effect on the next stb. Entering bounce resumes in the state matching the current dir. No out jump occurs on any mode change.
- Arithmetic is unsigned, WIDTH bits. Out-of-range values are unreachable, so no saturation logic exists.
- en deasserted mid-period: the divider clears. The next tick occurs DIV_COUNT cycles after en returns high.
- rst asserted at any time: immediate return to the reset values, independent of clk.

## Timing
- First stb occurs DIV_COUNT cycles after the first clk edge with en=1 following rst deassertion. out and tick update on the same edge.
- Tick period is exactly DIV_COUNT cycles while en=1. tick and turn are high for exactly 1 cycle.
- Latency from stb to out change: 1 clk edge. There is no combinational path from inputs to outputs.

## Configuration
- BOUNCE_COUNTER_DWELL_EN defined:
  - Bounce adds states HOLD_TOP and HOLD_BOT.
  - At the endpoint tick, the FSM moves to HOLD_* with out unchanged, dir flipped and turn=1.
  - The next tick steps away from the endpoint with turn=0.
  - Each endpoint is therefore shown for two ticks.
  - Wrap modes and hold mode are unaffected.
- BOUNCE_COUNTER_DWELL_EN undefined: behaviour exactly as described in Operation; the HOLD_* states are not built.

## Structure
- Shared package bounce_counter_pkg contains:
  - mode encodings: MODE_UP_WRAP, MODE_DOWN_WRAP, MODE_BOUNCE, MODE_HOLD;
  - FSM state typedef with UP, DOWN, HOLD_TOP, HOLD_BOT.
- Sub-module tick_strobe (DIV_COUNT, DIV_WIDTH; ports clk, rst, en, stb). It is the one-cycle enable generator, reused in place of the legacy divided-clock divider.

## Test plan
All scenarios use WIDTH=4, MIN_VAL=2, MAX_VAL=5, DIV_COUNT=4.
- Reset, en=1, mode=10 → out on successive ticks 3,4,5,4,3,2,3. turn with the ticks showing 4 (after 5) and 3 (after 2). dir falls with the 4 after 5.
- mode=00 from reset → 3,4,5,2,3. turn only on the tick showing 2. dir stays 1.
- mode=01 from reset → 5,4,3,2,5. turn on the first 5 and on the second 5.
- Tick spacing: ticks exactly 4 cycles apart. en low for 2 cycles mid-period → next tick 4 cycles after en rises, out unchanged while en low. mode=11 → ticks continue, out constant, turn=0.
- rst pulse asserted between clk edges while out=4 in DOWN → out=2, dir=1, tick=0 immediately. The sequence restarts at 3 after 4 cycles.
- BOUNCE_COUNTER_DWELL_EN, mode=10 → 3,4,5,5,4,3,2,2,3. turn on the second tick of each endpoint pair.
